// File: rtl/alu_instr_sequencer_pkg.sv
// Shared constants for the phase-1 hardwired control sequencer.
//  - 4-bit state encodings for the fetch/execute sequence
//  - instruction opcode values and the matching ALU operation selects
//  - bit positions of the IR fields
//  - decoded-opcode bundle produced by the opcode decoder
package alu_instr_sequencer_pkg;

  localparam int STATE_W = 4;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_T0   = 4'd1;
  localparam logic [3:0] ST_T1   = 4'd2;
  localparam logic [3:0] ST_T2   = 4'd3;
  localparam logic [3:0] ST_T3   = 4'd4;
  localparam logic [3:0] ST_T4   = 4'd5;
  localparam logic [3:0] ST_T4W  = 4'd6;
  localparam logic [3:0] ST_T5   = 4'd7;
  localparam logic [3:0] ST_T6   = 4'd8;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_SHR = 5'b00111;
  localparam logic [4:0] OP_SHL = 5'b01000;
  localparam logic [4:0] OP_ROR = 5'b01001;
  localparam logic [4:0] OP_ROL = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;

  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_SUB = 6'd1;
  localparam logic [5:0] ALU_AND = 6'd2;
  localparam logic [5:0] ALU_OR  = 6'd3;
  localparam logic [5:0] ALU_SHR = 6'd4;
  localparam logic [5:0] ALU_SHL = 6'd5;
  localparam logic [5:0] ALU_ROR = 6'd6;
  localparam logic [5:0] ALU_ROL = 6'd7;
  localparam logic [5:0] ALU_MUL = 6'd8;
  localparam logic [5:0] ALU_DIV = 6'd9;
  localparam logic [5:0] ALU_NEG = 6'd10;
  localparam logic [5:0] ALU_NOT = 6'd11;

  localparam int IR_OP_HI = 31;
  localparam int IR_OP_LO = 27;
  localparam int IR_RA_HI = 26;
  localparam int IR_RA_LO = 23;
  localparam int IR_RB_HI = 22;
  localparam int IR_RB_LO = 19;
  localparam int IR_RC_HI = 18;
  localparam int IR_RC_LO = 15;

  // is_hilo marks MUL/DIV, whose 64-bit result is written to LO then HI.
  typedef struct packed {
    logic [5:0] op_select;
    logic       is_hilo;
    logic       legal;
  } op_info_t;

endpackage

// File: rtl/alu_instr_sequencer_op_decode.sv
// Combinational opcode decoder.
// Ports:
//   op        in  5  opcode field IR[31:27]
//   op_select out 6  ALU operation code (0 for undecoded opcodes)
//   is_hilo   out 1  opcode produces a HI/LO result pair (MUL, DIV)
//   legal     out 1  opcode is one of the supported ALU instructions
module alu_instr_sequencer_op_decode
  import alu_instr_sequencer_pkg::*;
(
  input  logic [4:0] op,
  output logic [5:0] op_select,
  output logic       is_hilo,
  output logic       legal
);

  op_info_t info;

  always_comb begin
    info = '{op_select: 6'd0, is_hilo: 1'b0, legal: 1'b1};
    case (op)
      OP_ADD:  info.op_select = ALU_ADD;
      OP_SUB:  info.op_select = ALU_SUB;
      OP_AND:  info.op_select = ALU_AND;
      OP_OR:   info.op_select = ALU_OR;
      OP_SHR:  info.op_select = ALU_SHR;
      OP_SHL:  info.op_select = ALU_SHL;
      OP_ROR:  info.op_select = ALU_ROR;
      OP_ROL:  info.op_select = ALU_ROL;
      OP_MUL:  begin info.op_select = ALU_MUL; info.is_hilo = 1'b1; end
      OP_DIV:  begin info.op_select = ALU_DIV; info.is_hilo = 1'b1; end
      OP_NEG:  info.op_select = ALU_NEG;
      OP_NOT:  info.op_select = ALU_NOT;
      default: info.legal = 1'b0;
    endcase
  end

  assign op_select = info.op_select;
  assign is_hilo   = info.is_hilo;
  assign legal     = info.legal;

endmodule

// File: rtl/alu_instr_sequencer.sv
// Hardwired control sequencer for the phase-1 DataPath. Walks each
// register-register ALU instruction through fetch (T0-T2), operand read
// (T3-T4), ALU wait (T4W) and write-back (T5, plus T6 for MUL/DIV).
// Ports:
//   Clock              in   1  system clock, rising edge
//   clear              in   1  asynchronous active-low reset
//   run                in   1  keep sequencing while high; stop at a T0 boundary when low
//   IR                 in  32  instruction register from DataPath
//   finished           in   1  ALU done level, only sampled in T4W
//   *out               out  1  bus drive selects (at most one high)
//   *in                out  1  register load enables
//   IncPC, Read, start out  1  PC increment, memory read, ALU start pulse
//   RFSelect           out  4  register-file index
//   opSelect           out  6  ALU operation code
//   busy               out  1  sequencer not idle
//   illegal            out  1  sticky error: undecoded opcode or ALU timeout
module alu_instr_sequencer
  import alu_instr_sequencer_pkg::*;
#(
  parameter int ALU_TIMEOUT = 64
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] IR,
  input  logic        finished,
  output logic        PCout,
  output logic        IRout,
  output logic        RYout,
  output logic        RZLOout,
  output logic        RZHIout,
  output logic        MARout,
  output logic        RHIout,
  output logic        RLOout,
  output logic        RFout,
  output logic        MDRout,
  output logic        PCin,
  output logic        IRin,
  output logic        RYin,
  output logic        RZin,
  output logic        MARin,
  output logic        RHIin,
  output logic        RLOin,
  output logic        RFin,
  output logic        MDRin,
  output logic        IncPC,
  output logic        Read,
  output logic        start,
  output logic [3:0]  RFSelect,
  output logic [5:0]  opSelect,
  output logic        busy,
  output logic        illegal
);

  localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               illegal_q, illegal_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic [5:0] dec_op_select;
  logic       dec_is_hilo;
  logic       dec_legal;
  logic       unused_ir_bits;

  assign op = IR[IR_OP_HI:IR_OP_LO];
  assign ra = IR[IR_RA_HI:IR_RA_LO];
  assign rb = IR[IR_RB_HI:IR_RB_LO];
  assign rc = IR[IR_RC_HI:IR_RC_LO];
  assign unused_ir_bits = ^IR[IR_RC_LO-1:0];

  alu_instr_sequencer_op_decode u_op_decode (
    .op        (op),
    .op_select (dec_op_select),
    .is_hilo   (dec_is_hilo),
    .legal     (dec_legal)
  );

  // Next-state logic. Every instruction end (normal, illegal or timeout)
  // goes through the same run check so a dropped run always lands in IDLE
  // only at an instruction boundary.
  always_comb begin
    logic [STATE_W-1:0] end_state;
    end_state = run ? ST_T0 : ST_IDLE;
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        if (!dec_legal) begin
          illegal_d = 1'b1;
          state_d   = end_state;
        end else begin
          cnt_d   = '0;
          state_d = ST_T4;
        end
      end
      // finished is deliberately not looked at here: a stale done level
      // from the previous operation must not complete this one.
      ST_T4: state_d = ST_T4W;
      ST_T4W: begin
        if (finished) begin
          state_d = ST_T5;
        end else if (cnt_q == CNT_LAST) begin
          illegal_d = 1'b1;
          state_d   = end_state;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_T5:   state_d = dec_is_hilo ? ST_T6 : end_state;
      ST_T6:   state_d = end_state;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, timeout counter and sticky error flag.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Output decode from the registered state and IR only, so the async
  // clear forces every control line low without waiting for an edge.
  always_comb begin
    PCout = 1'b0; IRout = 1'b0; RYout = 1'b0; RZLOout = 1'b0; RZHIout = 1'b0;
    MARout = 1'b0; RHIout = 1'b0; RLOout = 1'b0; RFout = 1'b0; MDRout = 1'b0;
    PCin = 1'b0; IRin = 1'b0; RYin = 1'b0; RZin = 1'b0; MARin = 1'b0;
    RHIin = 1'b0; RLOin = 1'b0; RFin = 1'b0; MDRin = 1'b0;
    IncPC = 1'b0; Read = 1'b0; start = 1'b0;
    RFSelect = 4'd0;
    opSelect = 6'd0;
    case (state_q)
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1;
      end
      ST_T1: begin
        RZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3: begin
        RFSelect = rb; RFout = 1'b1; RYin = 1'b1;
      end
      ST_T4: begin
        RFSelect = rc; RFout = 1'b1; opSelect = dec_op_select;
        RZin = 1'b1; start = 1'b1;
      end
      ST_T4W: begin
        opSelect = dec_op_select; RZin = 1'b1;
      end
      ST_T5: begin
        RZLOout = 1'b1;
        if (dec_is_hilo) begin
          RLOin = 1'b1;
        end else begin
          RFSelect = ra; RFin = 1'b1;
        end
      end
      ST_T6: begin
        RZHIout = 1'b1; RHIin = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign illegal = illegal_q;

endmodule
